// File: rtl/ram_sdp_v2.sv
// rtl/ram_sdp_v2.sv - simple-dual-port RAM with byte enables, RDW mode, optional output stage and clear sequencer
// Optional per-lane even parity enabled by defining RAM_PARITY_EN.
module ram_sdp_v2 #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 6,
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   we_in,
    input  logic [ADDR_W-1:0]      write_addr,
    input  logic [DATA_W-1:0]      data_in,
    input  logic [DATA_W/8-1:0]    be_in,
    input  logic                   re_in,
    input  logic [ADDR_W-1:0]      read_addr,
`ifdef RAM_PARITY_EN
    input  logic                   par_flip_in,
    output logic                   parity_err,
`endif
    output logic [DATA_W-1:0]      data_out,
    output logic                   rd_valid,
    output logic                   init_busy
);

    localparam int NB    = DATA_W / 8;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic                r_init_busy;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_clear;
    logic                w_rd_en;
    logic                w_mem_we;
    logic [ADDR_W-1:0]   w_mem_addr;
    logic [DATA_W-1:0]   w_mem_data;
    logic [NB-1:0]       w_mem_be;
    logic                w_hit;
    logic [DATA_W-1:0]   w_rd_data;

    logic                r_s1_valid;
    logic [DATA_W-1:0]   r_s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CLEAR;
            r_clr_cnt   <= '0;
            r_init_busy <= 1'b1;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (&r_clr_cnt) begin
                        r_state     <= ST_READY;
                        r_init_busy <= 1'b0;
                    end
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    assign init_busy = r_init_busy;
    assign w_clear   = (r_state == ST_CLEAR);
    assign w_rd_en   = ~rst & ~w_clear & re_in;
    assign w_mem_we  = ~rst & (w_clear | we_in);

    // The clear sequencer owns the write port until READY.
    always_comb begin
        w_mem_addr = write_addr;
        w_mem_data = data_in;
        w_mem_be   = be_in;
        if (w_clear) begin
            w_mem_addr = r_clr_cnt;
            w_mem_data = '0;
            w_mem_be   = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_mem_be[i]) r_mem[w_mem_addr][8*i +: 8] <= w_mem_data[8*i +: 8];
            end
        end
    end

    assign w_hit = (RDW_MODE == 1) && we_in && (write_addr == read_addr);

    always_comb begin
        w_rd_data = r_mem[read_addr];
        for (int i = 0; i < NB; i++) begin
            if (w_hit && be_in[i]) w_rd_data[8*i +: 8] = data_in[8*i +: 8];
        end
    end

`ifdef RAM_PARITY_EN
    logic [NB-1:0] r_par [DEPTH];
    logic [NB-1:0] w_mem_par;
    logic [NB-1:0] w_rd_par;
    logic          w_rd_perr;
    logic          r_s1_perr;

    always_comb begin
        w_mem_par = '0;
        w_rd_par  = r_par[read_addr];
        w_rd_perr = 1'b0;
        for (int i = 0; i < NB; i++) begin
            w_mem_par[i] = ^w_mem_data[8*i +: 8] ^ (~w_clear & par_flip_in);
            if (w_hit && be_in[i]) w_rd_par[i] = w_mem_par[i];
            w_rd_perr = w_rd_perr | (w_rd_par[i] ^ (^w_rd_data[8*i +: 8]));
        end
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            for (int i = 0; i < NB; i++) begin
                if (w_mem_be[i]) r_par[w_mem_addr][i] <= w_mem_par[i];
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
`ifdef RAM_PARITY_EN
            r_s1_perr  <= 1'b0;
`endif
        end else begin
            r_s1_valid <= w_rd_en;
            if (w_rd_en) r_s1_data <= w_rd_data;
`ifdef RAM_PARITY_EN
            r_s1_perr  <= w_rd_en & w_rd_perr;
`endif
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic              r_s2_valid;
            logic [DATA_W-1:0] r_s2_data;
`ifdef RAM_PARITY_EN
            logic              r_s2_perr;
`endif
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
`ifdef RAM_PARITY_EN
                    r_s2_perr  <= 1'b0;
`endif
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) r_s2_data <= r_s1_data;
`ifdef RAM_PARITY_EN
                    r_s2_perr  <= r_s1_valid & r_s1_perr;
`endif
                end
            end
            assign data_out = r_s2_data;
            assign rd_valid = r_s2_valid;
`ifdef RAM_PARITY_EN
            assign parity_err = r_s2_perr;
`endif
        end else begin : g_no_out_reg
            assign data_out = r_s1_data;
            assign rd_valid = r_s1_valid;
`ifdef RAM_PARITY_EN
            assign parity_err = r_s1_perr;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_ram_sdp_v2.sv
// tb/tb_ram_sdp_v2.sv - scoreboard bench for ram_sdp_v2 (16x16, RAM_PARITY_EN optional)
module tb_ram_sdp_v2 #(
    parameter int RDW_MODE = 0,
    parameter int OUT_REG  = 0
);
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              we_in = 1'b0;
    logic [ADDR_W-1:0] write_addr = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic [1:0]        be_in = '0;
    logic              re_in = 1'b0;
    logic [ADDR_W-1:0] read_addr = '0;
    logic              par_flip_in = 1'b0;
    logic              parity_err;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              init_busy;

    ram_sdp_v2 #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RDW_MODE(RDW_MODE), .OUT_REG(OUT_REG)) dut (
        .clk(clk), .rst(rst), .we_in(we_in), .write_addr(write_addr), .data_in(data_in),
        .be_in(be_in), .re_in(re_in), .read_addr(read_addr),
`ifdef RAM_PARITY_EN
        .par_flip_in(par_flip_in), .parity_err(parity_err),
`endif
        .data_out(data_out), .rd_valid(rd_valid), .init_busy(init_busy)
    );
`ifndef RAM_PARITY_EN
    assign parity_err = 1'b0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic              perr;
        int                cyc;
    } exp_t;

    exp_t              sb[$];
    int                cyc = 0;
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] model [DEPTH];
    logic [1:0]        bad [DEPTH];
    logic [DATA_W-1:0] last_exp = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rd_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_rd_valid", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rd_data", data_out, e.data);
                check("rd_latency", cyc - e.cyc, 1 + OUT_REG);
`ifdef RAM_PARITY_EN
                check("parity_err", parity_err, e.perr);
`endif
            end
        end
    end

    task automatic do_cycle(input logic we, input logic [3:0] wa, input logic [15:0] d,
                            input logic [1:0] be, input logic re, input logic [3:0] ra,
                            input logic flip);
        exp_t e;
        we_in = we; write_addr = wa; data_in = d; be_in = be;
        re_in = re; read_addr = ra; par_flip_in = flip;
        if (re) begin
            e.data = model[ra];
            e.perr = |bad[ra];
            if (RDW_MODE == 1 && we && wa == ra) begin
                e.perr = 1'b0;
                for (int i = 0; i < 2; i++) begin
                    if (be[i]) e.data[8*i +: 8] = d[8*i +: 8];
                    e.perr = e.perr | (be[i] ? flip : bad[ra][i]);
                end
            end
            e.cyc = cyc;
            sb.push_back(e);
            last_exp = e.data;
        end
        if (we) begin
            for (int i = 0; i < 2; i++) begin
                if (be[i]) begin
                    model[wa][8*i +: 8] = d[8*i +: 8];
                    bad[wa][i] = flip;
                end
            end
        end
        @(posedge clk); #1;
        we_in = 1'b0; re_in = 1'b0; par_flip_in = 1'b0;
    endtask

    task automatic wait_clear();
        int n = 0;
        while (init_busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        we_in = 1'b0; re_in = 1'b0;
        check("clear_cycles", n, DEPTH);
        for (int i = 0; i < DEPTH; i++) begin
            model[i] = '0;
            bad[i] = '0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        // Reset with user traffic that must be ignored through the clear.
        we_in = 1'b1; re_in = 1'b1; data_in = 16'hBEEF; be_in = 2'b11;
        write_addr = 4'd9; read_addr = 4'd9;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data_out", data_out, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_init_busy", init_busy, 1);
        check("rst_parity_err", parity_err, 0);
        rst = 1'b0;
        wait_clear();

        for (int a = 0; a < DEPTH; a++) do_cycle(0, 0, 0, 0, 1, 4'(a), 0);

        do_cycle(1, 4'd5, 16'hA5C3, 2'b11, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 4'd5, 0);

        do_cycle(1, 4'd3, 16'h1234, 2'b11, 0, 0, 0);
        do_cycle(1, 4'd3, 16'hFFFF, 2'b01, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 4'd3, 0);

        do_cycle(1, 4'd7, 16'h1111, 2'b11, 0, 0, 0);
        do_cycle(1, 4'd7, 16'h2222, 2'b11, 1, 4'd7, 0);
        do_cycle(1, 4'd7, 16'hABCD, 2'b10, 1, 4'd7, 0);
        do_cycle(1, 4'd7, 16'h5555, 2'b00, 1, 4'd7, 0);
        do_cycle(0, 0, 0, 0, 1, 4'd7, 0);
        do_cycle(1, 4'd8, 16'h7777, 2'b11, 1, 4'd7, 0);

        for (int k = 0; k < 60; k++) begin
            do_cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 16'($urandom),
                     2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                     4'($urandom_range(0, 15)), 0);
        end

        idle(4);
        check("drain", sb.size(), 0);
        check("hold_data_out", data_out, last_exp);
        check("idle_rd_valid", rd_valid, 0);

`ifdef RAM_PARITY_EN
        do_cycle(1, 4'd2, 16'h00FF, 2'b11, 0, 0, 1);
        do_cycle(1, 4'd4, 16'h00FF, 2'b11, 0, 0, 0);
        do_cycle(0, 0, 0, 0, 1, 4'd2, 0);
        do_cycle(0, 0, 0, 0, 1, 4'd4, 0);
        do_cycle(1, 4'd6, 16'h0F0F, 2'b01, 1, 4'd6, 1);
        idle(4);
`endif

        // Fill with nonzero data so a short or misplaced clear is visible.
        for (int a = 0; a < DEPTH; a++) do_cycle(1, 4'(a), 16'h8000 | 16'(a), 2'b11, 0, 0, 0);

        // Read in flight when reset hits: only OUT_REG=0 completes before the reset edge.
        we_in = 1'b0; re_in = 1'b1; read_addr = 4'd1;
        if (OUT_REG == 0) begin
            exp_t e;
            e.data = model[1]; e.perr = 1'b0; e.cyc = cyc;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        re_in = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        check("rst2_rd_valid", rd_valid, 0);
        check("rst2_data_out", data_out, 0);
        check("rst2_init_busy", init_busy, 1);
        rst = 1'b0;
        we_in = 1'b1; write_addr = 4'd12; data_in = 16'hDEAD; be_in = 2'b11;
        idle(4);
        check("mid_clear_busy", init_busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        we_in = 1'b1; write_addr = 4'd0; data_in = 16'hCAFE;
        wait_clear();

        for (int a = 0; a < DEPTH; a++) do_cycle(0, 0, 0, 0, 1, 4'(a), 0);
        idle(4);
        check("final_drain", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule
